// File: rtl/cacheline_adapter_pkg.sv
// cacheline_adapter_pkg: shared types and constants for the line-to-burst adapter
package cacheline_adapter_pkg;
  localparam int LINE_W = 256;
  localparam int LINE_OFFSET_W = 5;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP} adapter_state_t;
  function automatic int beats(int beat_w);
    return LINE_W / beat_w;
  endfunction
endpackage

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: 256-bit cache line port to BEAT_W-bit memory bursts
// Define CACHELINE_ADAPTER_ASSERT_EN to compile in simulation protocol checks.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);
  localparam int BEATS = beats(BEAT_W);
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  adapter_state_t state, state_n;
  logic [31:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0] cnt;
  logic rd_q;
  logic last;
  logic unused_offset;
  assign last = cnt == LAST;
  assign unused_offset = &{1'b0, dfp_addr[LINE_OFFSET_W-1:0]};
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = dfp_write ? WR_DATA : dfp_read ? RD_REQ : IDLE;
      RD_REQ:  state_n = mem_ready ? RD_DATA : RD_REQ;
      RD_DATA: state_n = mem_rvalid && last ? RESP : RD_DATA;
      WR_DATA: state_n = mem_ready && last ? RESP : WR_DATA;
      default: state_n = IDLE;
    endcase
  end
  // one line buffer serves both read assembly and write beat sourcing
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      line_q <= '0;
      cnt    <= '0;
      rd_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (dfp_write || dfp_read) begin
          addr_q <= {dfp_addr[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
          rd_q   <= !dfp_write;
          cnt    <= '0;
          if (dfp_write) line_q <= dfp_wdata;
        end
        RD_DATA: if (mem_rvalid) begin
          line_q[cnt*BEAT_W +: BEAT_W] <= mem_rdata;
          cnt <= cnt + 1'b1;
        end
        WR_DATA: if (mem_ready) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end
  always_comb begin
    mem_read  = state == RD_REQ;
    mem_write = state == WR_DATA;
    mem_addr  = (state == RD_REQ || state == WR_DATA) ? addr_q : '0;
    mem_wdata = state == WR_DATA ? line_q[cnt*BEAT_W +: BEAT_W] : '0;
    dfp_resp  = state == RESP;
    dfp_rdata = (state == RESP && rd_q) ? line_q : '0;
  end
`ifdef CACHELINE_ADAPTER_ASSERT_EN
  logic resp_q;
  always_ff @(posedge clk) begin
    if (rst) resp_q <= 1'b0;
    else resp_q <= dfp_resp;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE) begin
        assert (!(dfp_read && dfp_write)) else $error("dfp_read and dfp_write both high");
        if (dfp_read || dfp_write)
          assert (dfp_addr[LINE_OFFSET_W-1:0] == '0) else $error("unaligned line address");
      end
      if (state != IDLE)
        assert (dfp_addr[31:LINE_OFFSET_W] == addr_q[31:LINE_OFFSET_W]) else $error("dfp_addr changed mid-request");
      if ((state == WR_DATA || state == RESP) && !rd_q)
        assert (dfp_wdata == line_q) else $error("dfp_wdata changed mid-write");
      assert (!mem_rvalid || state == RD_REQ || state == RD_DATA) else $error("mem_rvalid outside read");
      assert (!(dfp_resp && resp_q)) else $error("dfp_resp held two cycles");
    end
  end
`endif
endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Responder for the cache's downward-facing 256-bit line port. It accepts one line read or one line writeback at a time, and converts each request into a 4-beat, 64-bit burst on the memory port. For reads it assembles the 4 beats into a line, then returns it with a single-cycle `dfp_resp`. It sits between the 4-way write-back cache and the burst memory model/controller.

## Interface
- `BEAT_W`, 64, memory beat width; must divide 256; `BEATS = 256/BEAT_W` (default 4)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `dfp_addr`  in  32  line address from cache; `[4:0]` ignored (forced 0 downstream)
- `dfp_read`  in  1  line read request, level, held until `dfp_resp`
- `dfp_write`  in  1  line write request, level, held until `dfp_resp`
- `dfp_wdata`  in  256  write line, valid while `dfp_write`
- `dfp_rdata`  out  256  read line, valid only in the `dfp_resp` cycle of a read
- `dfp_resp`  out  1  one-cycle completion pulse
- `mem_addr`  out  32  burst base address, `{line_addr[31:5],5'b0}`
- `mem_read`  out  1  burst read command, held until accepted by `mem_ready`
- `mem_write`  out  1  write beat valid
- `mem_wdata`  out  BEAT_W  write beat, beat 0 = line bits `[BEAT_W-1:0]`
- `mem_ready`  in  1  memory accepts the command or beat this cycle
- `mem_rdata`  in  BEAT_W  read beat
- `mem_rvalid`  in  1  read beat valid; beats arrive in ascending order

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE:
  - `dfp_write` latches the address and the 256-bit `dfp_wdata`, clears the beat counter, and moves to WR_DATA.
  - Otherwise, `dfp_read` latches the address and moves to RD_REQ.
  - Write has priority when both requests are high (illegal condition).
- RD_REQ: drives `mem_read=1` and `mem_addr`. When `mem_ready=1`, moves to RD_DATA.
- RD_DATA:
  - Each `mem_rvalid` stores `mem_rdata` into buffer slice `cnt` and increments `cnt`.
  - On the beat with `cnt==BEATS-1`, moves to RESP.
- WR_DATA:
  - Drives `mem_write=1`, `mem_addr`, and `mem_wdata` = latched slice `cnt`.
  - On `mem_ready`, increments `cnt`. On the last beat accepted, moves to RESP.
  - While `mem_ready=0`, the beat and address hold stable.
- RESP:
  - `dfp_resp=1`. `dfp_rdata` = assembled buffer for a read, 0 for a write.
  - Unconditionally moves to IDLE.
  - Requests are not sampled in RESP; a request still high that cycle is the completed one.
- `mem_rvalid` outside RD_DATA is ignored.
- `cnt` is `$clog2(BEATS)` bits and wraps to 0 after the last beat.

## Timing
- Reset values: `dfp_resp=0`, `dfp_rdata=0`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`; state IDLE; `cnt=0`; buffer 0.
- All outputs are decoded from registered state and data only; there is no combinational path from `dfp_*` inputs to `mem_*` outputs.
- Read, zero stall: request seen in IDLE at cycle N.
  - `mem_read` at N+1.
  - Earliest beats at N+2..N+5.
  - `dfp_resp` at N+6.
- Write, zero stall: request seen at N.
  - Beats at N+1..N+4.
  - `dfp_resp` at N+5.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after RESP. This covers the cache's WRITEBACK→ALLOCATE transition, which raises `dfp_read` the cycle after the write response.
- Reset mid-burst: the next cycle is IDLE with all outputs at reset values. The partial line is discarded. Late `mem_rvalid` beats are ignored. No `dfp_resp` is issued for the aborted request.

## Configuration
- `CACHELINE_ADAPTER_ASSERT_EN` defined: simulation assertions are compiled in. They check:
  - `dfp_read && dfp_write` never both high in IDLE.
  - `dfp_addr[4:0]==0` on acceptance.
  - `dfp_addr`, and `dfp_wdata` for writes, stable from acceptance to `dfp_resp`.
  - No `mem_rvalid` outside RD_REQ/RD_DATA.
  - `dfp_resp` never high for 2 consecutive cycles.
- Not defined: no checks are compiled. Functional behaviour is identical in both cases.

## Structure
- Package `cacheline_adapter_pkg` holds:
  - the state enum `adapter_state_t`
  - the constants `LINE_W=256`, `LINE_OFFSET_W=5`
  - the function `beats(BEAT_W)`
- No sub-module: the block is a single FSM plus an address register, a 256-bit line buffer (shared by read assembly and write data), and a beat counter.

## Test plan
- Read, zero stall, addr `0x0000_1A20`, beats `0x11..11`,`0x22..22`,`0x33..33`,`0x44..44` → `mem_read` for 1 cycle at `0x0000_1A20`; `dfp_resp` 6 cycles after acceptance with `dfp_rdata={0x44..44,0x33..33,0x22..22,0x11..11}`.
- Write, `mem_ready` low for 3 cycles on beat 2, line `0xDEAD...` → 4 `mem_write` beats in order, beat 2 held 4 cycles; `dfp_resp` at N+8.
- Writeback then allocate: write to `0x0000_2000`, then read of `0x0000_4000` raised the cycle after `dfp_resp` → read accepted in the IDLE cycle, `mem_addr=0x0000_4000`, exactly 2 `dfp_resp` pulses.
- `rst` asserted after 2 read beats → outputs zero next cycle; the remaining 2 beats are ignored; a following read returns the correct fresh line.
- Spurious `mem_rvalid` in IDLE with value `0xFF..FF` → no state change; next read's `dfp_rdata` is unaffected.
- With `CACHELINE_ADAPTER_ASSERT_EN`, drive `dfp_read` and `dfp_write` together → assertion fires; the write burst proceeds.
